// File: rtl/player_input_decoder.sv
// Decodes PS/2 scan codes and debounced shake sensors into per-player one-cycle key events.
// Latency: key event one cycle after the strobe; shake event DEBOUNCE_CYCLES+3 cycles after a clean rise.
// No backpressure: every strobe is consumed; a shake colliding with a key is deferred one cycle.
module player_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       shake1_in,
  input  logic       shake2_in,
  output logic       p1_key_pressed,
  output logic [7:0] p1_arrow,
  output logic       p2_key_pressed,
  output logic [7:0] p2_arrow
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_EXT       = 2'd1;
  localparam logic [1:0] ST_BREAK     = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [2:0]       CODE_SHAKE = 3'd5;
  localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);

  // Returns {hit, key index}. Index bit 2 selects the player, bits 1:0 the
  // direction (up, left, down, right). Player 1 keys only exist unextended.
  function automatic logic [3:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    case (code)
      8'h1D:   r = {~ext, 3'd0};
      8'h1C:   r = {~ext, 3'd1};
      8'h1B:   r = {~ext, 3'd2};
      8'h23:   r = {~ext, 3'd3};
      8'h75:   r = {1'b1, 3'd4};
      8'h6B:   r = {1'b1, 3'd5};
      8'h72:   r = {1'b1, 3'd6};
      8'h74:   r = {1'b1, 3'd7};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [7:0]            held_q, held_d;
  logic [1:0]            sync_a_q, sync_a_d;
  logic [1:0]            sync_b_q, sync_b_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][2:0]       arrow_q, arrow_d;

  logic                  is_make;
  logic                  is_release;
  logic [3:0]            lk;
  logic [1:0]            key_evt;
  logic [1:0][2:0]       key_code;
  logic [1:0]            shake_evt;
  logic [1:0]            shake_raw;

  assign shake_raw = {shake2_in, shake1_in};

  // Scan-code sequencer: tracks E0/F0 prefixes, held flags suppress typematic repeats.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    is_make    = 1'b0;
    is_release = 1'b0;
    lk         = 4'b0000;
    key_evt    = 2'b00;
    key_code   = '0;
    if (ps2_key_pressed) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_key_data == SC_BREAK) begin
            state_d = ST_BREAK;
          end else begin
            lk      = key_lookup(ps2_key_data, 1'b0);
            is_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_key_data == SC_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            lk      = key_lookup(ps2_key_data, 1'b1);
            is_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BREAK: begin
          lk         = key_lookup(ps2_key_data, 1'b0);
          is_release = 1'b1;
          state_d    = ST_IDLE;
        end
        default: begin
          lk         = key_lookup(ps2_key_data, 1'b1);
          is_release = 1'b1;
          state_d    = ST_IDLE;
        end
      endcase
    end
    if (is_make && lk[3] && !held_q[lk[2:0]]) begin
      held_d[lk[2:0]]  = 1'b1;
      key_evt[lk[2]]   = 1'b1;
      key_code[lk[2]]  = {1'b0, lk[1:0]} + 3'd1;
    end
    if (is_release && lk[3]) begin
      held_d[lk[2:0]] = 1'b0;
    end
  end

  // Shake sensors: two-flop synchronizer, then a level must disagree for
  // DEBOUNCE_CYCLES consecutive cycles before it is accepted; only rises are events.
  always_comb begin
    sync_a_d  = shake_raw;
    sync_b_d  = sync_a_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    shake_evt = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (sync_b_q[p] != deb_q[p]) begin
        if (cnt_q[p] == DEB_LIMIT) begin
          deb_d[p]     = ~deb_q[p];
          shake_evt[p] = ~deb_q[p];
        end else begin
          cnt_d[p] = cnt_q[p] + CNT_W'(1);
        end
      end
    end
  end

  // Per-player output arbitration: key wins a collision, shake waits one cycle in pend.
  always_comb begin
    pulse_d = 2'b00;
    arrow_d = arrow_q;
    pend_d  = pend_q;
    for (int p = 0; p < 2; p++) begin
      if (key_evt[p]) begin
        pulse_d[p] = 1'b1;
        arrow_d[p] = key_code[p];
        pend_d[p]  = pend_q[p] | shake_evt[p];
      end else if (pend_q[p] || shake_evt[p]) begin
        pulse_d[p] = 1'b1;
        arrow_d[p] = CODE_SHAKE;
        pend_d[p]  = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      held_q   <= '0;
      sync_a_q <= '0;
      sync_b_q <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pulse_q  <= '0;
      arrow_q  <= '0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
      arrow_q  <= arrow_d;
    end
  end

  assign p1_key_pressed = pulse_q[0];
  assign p1_arrow       = {5'b00000, arrow_q[0]};
  assign p2_key_pressed = pulse_q[1];
  assign p2_arrow       = {5'b00000, arrow_q[1]};

endmodule

// File: tb/tb_player_input_decoder.sv
// Bench for player_input_decoder: expected events are queued with their due cycle
// when stimulus is driven; a negedge monitor pops and compares every output pulse.
module tb_player_input_decoder;

  localparam int DEB = 8;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       shake1_in;
  logic       shake2_in;
  logic       p1_key_pressed;
  logic [7:0] p1_arrow;
  logic       p2_key_pressed;
  logic [7:0] p2_arrow;

  typedef struct {
    int         cyc;
    logic [7:0] arrow;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1;
  exp_t m2;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  player_input_decoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .shake1_in      (shake1_in),
    .shake2_in      (shake2_in),
    .p1_key_pressed (p1_key_pressed),
    .p1_arrow       (p1_arrow),
    .p2_key_pressed (p2_key_pressed),
    .p2_arrow       (p2_arrow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the head of its player's queue in cycle and code.
  always @(negedge clock) begin
    if (p1_key_pressed === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL p1_unexpected_pulse: cycle %0d arrow %02h, required no pulse", cyc, p1_arrow);
      end else begin
        m1 = q1.pop_front();
        if (m1.cyc != cyc || p1_arrow !== m1.arrow) begin
          errors++;
          $display("FAIL p1_event: cycle %0d arrow %02h, required cycle %0d arrow %02h",
                   cyc, p1_arrow, m1.cyc, m1.arrow);
        end
      end
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      checks++;
      errors++;
      m1 = q1.pop_front();
      $display("FAIL p1_missing_pulse: no pulse at cycle %0d, required arrow %02h at cycle %0d",
               cyc, m1.arrow, m1.cyc);
    end
    if (p2_key_pressed === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL p2_unexpected_pulse: cycle %0d arrow %02h, required no pulse", cyc, p2_arrow);
      end else begin
        m2 = q2.pop_front();
        if (m2.cyc != cyc || p2_arrow !== m2.arrow) begin
          errors++;
          $display("FAIL p2_event: cycle %0d arrow %02h, required cycle %0d arrow %02h",
                   cyc, p2_arrow, m2.cyc, m2.arrow);
        end
      end
    end else if (q2.size() != 0 && q2[0].cyc <= cyc) begin
      checks++;
      errors++;
      m2 = q2.pop_front();
      $display("FAIL p2_missing_pulse: no pulse at cycle %0d, required arrow %02h at cycle %0d",
               cyc, m2.arrow, m2.cyc);
    end
  end

  task automatic expect1(input logic [7:0] a, input int dly);
    exp_t e;
    e.cyc   = cyc + dly;
    e.arrow = a;
    q1.push_back(e);
  endtask

  task automatic expect2(input logic [7:0] a, input int dly);
    exp_t e;
    e.cyc   = cyc + dly;
    e.arrow = a;
    q2.push_back(e);
  endtask

  // Drives one strobe for one cycle; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    ps2_key_pressed = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    resetn          = 1'b0;
    ps2_key_data    = 8'h00;
    ps2_key_pressed = 1'b0;
    shake1_in       = 1'b0;
    shake2_in       = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (p1_key_pressed !== 1'b0 || p2_key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: p1 %b p2 %b, required 0 0", p1_key_pressed, p2_key_pressed);
    end
    checks++;
    if (p1_arrow !== 8'h00 || p2_arrow !== 8'h00) begin
      errors++;
      $display("FAIL reset_arrows: p1 %02h p2 %02h, required 00 00", p1_arrow, p2_arrow);
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_key;
    expect1(8'h01, 1);
    send(8'h1D);
    idle(4);
    checks++;
    if (p1_arrow !== 8'h01) begin
      errors++;
      $display("FAIL single_key_hold: p1_arrow %02h, required 01", p1_arrow);
    end
    checks++;
    if (p2_arrow !== 8'h00) begin
      errors++;
      $display("FAIL single_key_p2: p2_arrow %02h, required 00", p2_arrow);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL single_key_pending: %0d events outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_typematic;
    send(8'hF0);
    send(8'h1D);
    idle(2);
    expect1(8'h01, 1);
    send(8'h1D);
    send(8'h1D);
    send(8'hF0);
    send(8'h1D);
    expect1(8'h01, 1);
    send(8'h1D);
    idle(4);
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL typematic_pending: %0d events outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_extended;
    send(8'hE0);
    expect2(8'h01, 1);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    expect2(8'h02, 1);
    send(8'h6B);
    send(8'hF0);
    send(8'h1D);
    send(8'hE0);
    send(8'h1D);
    expect1(8'h01, 1);
    send(8'h1D);
    idle(4);
    checks++;
    if (p2_arrow !== 8'h02) begin
      errors++;
      $display("FAIL extended_p2_hold: p2_arrow %02h, required 02", p2_arrow);
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL extended_pending: p1 %0d p2 %0d outstanding, required 0 0", q1.size(), q2.size());
    end
  endtask

  task automatic test_shake_debounce;
    shake1_in = 1'b1;
    idle(3);
    shake1_in = 1'b0;
    idle(20);
    expect1(8'h05, 2 + DEB + 1);
    shake1_in = 1'b1;
    idle(40);
    checks++;
    if (p1_arrow !== 8'h05) begin
      errors++;
      $display("FAIL shake_hold: p1_arrow %02h, required 05", p1_arrow);
    end
    shake1_in = 1'b0;
    idle(20);
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL shake_pending: %0d events outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_collision;
    shake1_in = 1'b1;
    shake2_in = 1'b1;
    expect2(8'h05, 2 + DEB + 1);
    idle(2 + DEB);
    expect1(8'h04, 1);
    send(8'h23);
    expect1(8'h05, 1);
    checks++;
    if (p1_key_pressed !== 1'b1 || p2_key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL collision_same_cycle: p1 %b p2 %b, required 1 1", p1_key_pressed, p2_key_pressed);
    end
    idle(4);
    shake1_in = 1'b0;
    shake2_in = 1'b0;
    idle(20);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL collision_pending: p1 %0d p2 %0d outstanding, required 0 0", q1.size(), q2.size());
    end
  endtask

  task automatic test_reset_mid;
    send(8'hF0);
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    checks++;
    if (p1_arrow !== 8'h00 || p2_arrow !== 8'h00 || p1_key_pressed !== 1'b0 || p2_key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: p1 %b/%02h p2 %b/%02h, required 0/00 0/00",
               p1_key_pressed, p1_arrow, p2_key_pressed, p2_arrow);
    end
    @(negedge clock);
    resetn = 1'b1;
    idle(1);
    expect1(8'h02, 1);
    send(8'h1C);
    idle(4);
    checks++;
    if (p1_arrow !== 8'h02) begin
      errors++;
      $display("FAIL reset_mid_key: p1_arrow %02h, required 02", p1_arrow);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending: %0d events outstanding, required 0", q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_typematic();
    test_extended();
    test_shake_debounce();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
